alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's single-cycle 32-bit add/sub/lt ALU.
- Operand width is generic, and the opcode set adds unsigned compare and bitwise ops.
- Produces carry/overflow/zero flags and accepts/returns operations over valid/ready handshakes with full backpressure.
- Sits between the issue logic and the writeback arbiter.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range 8..64.
- TAG_W, 4: width of the opaque tag carried alongside each operation for writeback matching.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted this cycle when in_valid and in_ready are both high.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode (alu_pipe_pkg::alu_op_e).
- in_tag  input  TAG_W  tag, returned unchanged.
- out_valid  output  1  result held on the output.
- out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
- out_result  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.
- out_flags  output  4  {illegal, zero, ovf, carry}.
- busy  output  1  high when any stage holds a valid operation.

Behaviour:
- Reset: all valid bits clear; out_result, out_tag and out_flags are 0; in_ready is 1; busy is 0. Reset asserts asynchronously and deasserts synchronously to clk via an external synchroniser. Reset mid-operation discards all in-flight operations; no partial output appears.
- Stage 1 (S1) registers a, b, op and tag on accept. Stage 2 (S2) registers result, flags and tag computed combinationally from S1.
- Latency: accept in cycle N gives out_valid in cycle N+2 when there is no backpressure. Throughput is 1 op/cycle.
- Handshake:
  - s2_free = !s2_valid || out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Stability: while out_valid && !out_ready, out_result, out_tag and out_flags hold stable and out_valid stays high.
- Simultaneous events: an output handshake and an input handshake in the same cycle with a full pipe moves all stages by one. No bubble and no loss.
- Opcodes:
  - 000 ADD: a + b.
  - 001 SUB: a + ~b + 1.
  - 010 LT: signed compare; result is zero-extended 1/0.
  - 011 LTU: unsigned compare; result is zero-extended 1/0.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 is illegal: result 0 and flags = 4'b1000.
- Arithmetic is WIDTH+1 bits internally.
  - carry = bit WIDTH of the sum. For SUB, carry = 1 means no borrow.
  - ovf = signed overflow, (a[msb]==b'[msb]) && (r[msb]!=a[msb]), where b' is the effective addend. It is valid for ADD/SUB and 0 otherwise.
  - zero = (result == 0), valid for every legal op.
  - carry is 0 for non-ADD/SUB ops.
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH unless the saturation feature below is enabled.
- busy = s1_valid || s2_valid.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- When defined, opcode 111 becomes ADDS: signed saturating add.
  - On positive overflow the result is the maximum signed value, 0111…1. On negative overflow it is the minimum, 1000…0.
  - ovf is set when clamping occurs; carry is 0.
  - 111 is then not illegal.
- When undefined, 111 is illegal as above, and no saturation logic is synthesised.

Decomposition:
- alu_pipe_pkg holds:
  - the alu_op_e enum (3-bit);
  - the flag-bit index localparams FLAG_CARRY = 0, FLAG_OVF = 1, FLAG_ZERO = 2, FLAG_ILLEGAL = 3;
  - a packed struct type for the flags.
- alu_pipe_core is one purely combinational sub-module. It takes a, b and op and returns result and flags, parametrised by WIDTH.
- alu_pipe itself contains only the pipeline registers and the handshake logic.

Test Plan:
- ADD, WIDTH=32, a=0xFFFFFFFF, b=1, out_ready=1 → result 0x00000000 two cycles after accept; flags zero=1, carry=1, ovf=0.
- SUB a=0x80000000, b=1 → result 0x7FFFFFFF with ovf=1, carry=1. LT with a=0xFFFFFFFF, b=0 → result 1. LTU with the same operands → result 0.
- Backpressure: issue tags 1, 2, 3 back-to-back with out_ready=0 → in_ready drops after two accepts and output holds tag 1 stable. Then raise out_ready → tags 1, 2, 3 emerge in consecutive cycles with no loss or duplication.
- Opcode 111 without ALU_PIPE_SAT_EN → result 0, flags 4'b1000. With the macro defined, ADDS a=0x7FFFFFF0, b=0x20 → result 0x7FFFFFFF, ovf=1.
- Reset mid-flight: two ops in the pipe, assert rst_n=0 between clock edges → out_valid and busy go 0 immediately, with no clock edge needed. After release, in_ready=1 and no stale result appears.
- WIDTH=8 instance: ADD 0x7F + 0x01 → result 0x80 with ovf=1 and carry=0. Random streaming of 1000 ops against a reference model, with random out_ready → all results and tags match, in order.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode, flag and helper definitions shared by the pipelined ALU.
// Optional feature macro: ALU_PIPE_SAT_EN (opcode 3'b111 becomes signed saturating add).
package alu_pipe_pkg;

    localparam int OP_W   = 3;
    localparam int FLAG_W = 4;

    // Opcode encoding; OP_RSVD is illegal unless saturation is built in
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_LT   = 3'b010,
        OP_LTU  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    // Bit positions of the flags inside the 4-bit flag word
    localparam int FLAG_CARRY   = 0;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_ILLEGAL = 3;

    // Packed view of the flag word, MSB first: {illegal, zero, ovf, carry}
    typedef struct packed {
        logic illegal;
        logic zero;
        logic ovf;
        logic carry;
    } alu_flags_t;

    // Converts a flag vector built with the FLAG_* indices into the struct view
    function automatic alu_flags_t to_flags(input logic [FLAG_W-1:0] v);
        alu_flags_t f;
        f.illegal = v[FLAG_ILLEGAL];
        f.zero    = v[FLAG_ZERO];
        f.ovf     = v[FLAG_OVF];
        f.carry   = v[FLAG_CARRY];
        return f;
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: purely combinational datapath of the pipelined ALU.
// Optional feature macro: ALU_PIPE_SAT_EN adds the ADDS (signed saturating add) opcode.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    localparam int MSB = WIDTH - 1;

    logic              carry_in;
    logic [WIDTH-1:0]  addend;
    logic [WIDTH:0]    sum;
    logic              add_ovf;
    logic [WIDTH-1:0]  res;
    logic [FLAG_W-1:0] flag_v;

    // One WIDTH+1 bit adder shared by ADD, SUB (inverted operand plus carry-in) and ADDS
    always_comb begin
        carry_in = (op_i == OP_SUB);
        addend   = carry_in ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
        add_ovf  = (a_i[MSB] == addend[MSB]) && (sum[MSB] != a_i[MSB]);
    end

    // Result selection and flag generation per opcode
    always_comb begin
        res    = '0;
        flag_v = '0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                res                = sum[MSB:0];
                flag_v[FLAG_CARRY] = sum[WIDTH];
                flag_v[FLAG_OVF]   = add_ovf;
            end
            OP_LT:  res = {{MSB{1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_LTU: res = {{MSB{1'b0}}, (a_i < b_i)};
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
`ifdef ALU_PIPE_SAT_EN
            OP_RSVD: begin
                if (add_ovf) begin
                    res = a_i[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
                end else begin
                    res = sum[MSB:0];
                end
                flag_v[FLAG_OVF] = add_ovf;
            end
`endif
            default: flag_v[FLAG_ILLEGAL] = 1'b1;
        endcase
        flag_v[FLAG_ZERO] = (res == '0) && !flag_v[FLAG_ILLEGAL];
    end

    assign result_o = res;
    assign flags_o  = to_flags(flag_v);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and full backpressure.
// Stage 1 holds the operands, stage 2 holds the computed result, flags and tag.
// Optional feature macro: ALU_PIPE_SAT_EN (handled inside alu_pipe_core).
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [3:0]        out_flags,
    output logic              busy
);

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    alu_op_e           s1_op_q, s1_op_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s2_result_q, s2_result_d;
    alu_flags_t        s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

    logic              s2_free;
    logic              s1_advance;
    logic              accept;
    logic [WIDTH-1:0]  core_result;
    alu_flags_t        core_flags;

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // Handshake: stage 2 can take new data when empty or being drained this cycle
    always_comb begin
        s2_free    = !s2_valid_q || out_ready;
        s1_advance = s1_valid_q && s2_free;
        in_ready   = !s1_valid_q || s2_free;
        accept     = in_valid && in_ready;
    end

    // Next-state for both stages; each stage holds unless it is loaded or drained
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_tag_d    = s2_tag_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = alu_op_e'(in_op);
            s1_tag_d   = in_tag;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s1_advance) begin
            s2_valid_d  = 1'b1;
            s2_result_d = core_result;
            s2_flags_d  = core_flags;
            s2_tag_d    = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards every in-flight operation at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_ADD;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;
    assign out_flags  = s2_flags_q;
    assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and streaming checks for alu_pipe (WIDTH=32 and WIDTH=8 instances).
// Honours ALU_PIPE_SAT_EN when choosing expectations for opcode 3'b111.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inA = '0;
    logic [31:0] inB = '0;
    logic [2:0]  inOp = '0;
    logic [3:0]  inTag = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] outResult;
    logic [3:0]  outTag;
    logic [3:0]  outFlags;
    logic        busy;

    logic        in8Valid = 1'b0;
    logic        in8Ready;
    logic [7:0]  in8A = '0;
    logic [7:0]  in8B = '0;
    logic [2:0]  in8Op = '0;
    logic [3:0]  in8Tag = '0;
    logic        out8Valid;
    logic        out8Ready = 1'b1;
    logic [7:0]  out8Result;
    logic [3:0]  out8Tag;
    logic [3:0]  out8Flags;
    logic        busy8;

    int checkCount = 0;
    int failCount = 0;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .in_op      (inOp),
        .in_tag     (inTag),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_tag    (outTag),
        .out_flags  (outFlags),
        .busy       (busy)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in8Valid),
        .in_ready   (in8Ready),
        .in_a       (in8A),
        .in_b       (in8B),
        .in_op      (in8Op),
        .in_tag     (in8Tag),
        .out_valid  (out8Valid),
        .out_ready  (out8Ready),
        .out_result (out8Result),
        .out_tag    (out8Tag),
        .out_flags  (out8Flags),
        .busy       (busy8)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Hard stop in case something never returns
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Counts one comparison and reports it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one operation into an idle 32-bit pipe and waits two cycles for its result
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, output logic earlyValid, output logic lateValid);
        @(negedge clk);
        outReady = 1'b1;
        inValid  = 1'b1;
        inOp     = op;
        inA      = a;
        inB      = b;
        inTag    = tag;
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        earlyValid = outValid;
        @(negedge clk);
        lateValid = outValid;
    endtask

    // One directed vector: latency, result, flags and tag
    task automatic runVector(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expRes, input logic [3:0] expFlags);
        logic earlyValid, lateValid;
        logic [3:0] tag;
        tag = a[3:0] ^ 4'h9;
        applyStimulus(op, a, b, tag, earlyValid, lateValid);
        checkOutput({name, "_validEarly"}, earlyValid, 0);
        checkOutput({name, "_validOnTime"}, lateValid, 1);
        checkOutput({name, "_result"}, outResult, expRes);
        checkOutput({name, "_flags"}, outFlags, expFlags);
        checkOutput({name, "_tag"}, outTag, tag);
    endtask

    // Operand source biased towards the signed/unsigned boundaries
    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference behaviour in plain integer arithmetic; returns {tag, flags, result}
    function automatic logic [39:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [3:0] tag);
        longint sa, sb, ua, ub, t;
        logic [31:0] r;
        logic c, v, z, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            3'b000: begin
                t = ua + ub; r = t[31:0]; c = (t > 64'sd4294967295);
                t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'b001: begin
                t = sa - sb; r = t[31:0]; c = (a >= b);
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'b010: r = (sa < sb) ? 32'd1 : 32'd0;
            3'b011: r = (ua < ub) ? 32'd1 : 32'd0;
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: begin
`ifdef ALU_PIPE_SAT_EN
                t = sa + sb;
                if (t > 64'sd2147483647) begin
                    r = 32'h7FFF_FFFF; v = 1'b1;
                end else if (t < -64'sd2147483648) begin
                    r = 32'h8000_0000; v = 1'b1;
                end else begin
                    r = t[31:0];
                end
`else
                ill = 1'b1;
`endif
            end
        endcase
        z = (r == 32'h0) && !ill;
        return {tag, ill, z, v, c, r};
    endfunction

    // Main sequence
    initial begin
        logic [7:0]  seen [5];
        logic [39:0] expected;
        logic [39:0] sbq [$];
        int stale;
        int accepted;
        int cycles;

        $display("[TB] start");

        #2;
        checkOutput("rst_outValid", outValid, 0);
        checkOutput("rst_inReady", inReady, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_result", outResult, 0);
        checkOutput("rst_tag", outTag, 0);
        checkOutput("rst_flags", outFlags, 0);
        checkOutput("rst_busy8", busy8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        runVector("addWrap",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101);
        runVector("addOvf",    OP_ADD, 32'h7FFF_FFF0, 32'h0000_0020, 32'h8000_0010, 4'b0010);
        runVector("subOvf",    OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        runVector("subZero",   OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0101);
        runVector("subBorrow", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0000);
        runVector("ltSigned",  OP_LT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 4'b0000);
        runVector("ltUnsigned",OP_LTU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0100);
        runVector("ltuTrue",   OP_LTU, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001, 4'b0000);
        runVector("and",       OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
        runVector("or",        OP_OR,  32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 4'b0000);
        runVector("xorZero",   OP_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b0100);
`ifdef ALU_PIPE_SAT_EN
        runVector("addsPos",   OP_RSVD, 32'h7FFF_FFF0, 32'h0000_0020, 32'h7FFF_FFFF, 4'b0010);
        runVector("addsNeg",   OP_RSVD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0010);
        runVector("addsPlain", OP_RSVD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 4'b0000);
`else
        runVector("illegal",   OP_RSVD, 32'h7FFF_FFF0, 32'h0000_0020, 32'h0000_0000, 4'b1000);
`endif

        // 8-bit instance: signed overflow without carry
        @(negedge clk);
        checkOutput("w8_inReady", in8Ready, 1);
        in8Valid = 1'b1; in8Op = OP_ADD; in8A = 8'h7F; in8B = 8'h01; in8Tag = 4'hA;
        @(posedge clk);
        #1 in8Valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("w8_valid", out8Valid, 1);
        checkOutput("w8_result", out8Result, 8'h80);
        checkOutput("w8_flags", out8Flags, 4'b0010);
        checkOutput("w8_tag", out8Tag, 4'hA);

        // Backpressure: two accepts fill the pipe, output holds, then drains in order
        @(negedge clk);
        outReady = 1'b0;
        inValid = 1'b1; inOp = OP_ADD; inA = 32'd1; inB = 32'd100; inTag = 4'd1;
        @(posedge clk);
        #1 inA = 32'd2; inB = 32'd200; inTag = 4'd2;
        @(posedge clk);
        #1 inA = 32'd3; inB = 32'd300; inTag = 4'd3;
        @(negedge clk);
        checkOutput("bp_inReadyLow", inReady, 0);
        checkOutput("bp_outValid", outValid, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_holdTag", outTag, 4'd1);
            checkOutput("bp_holdResult", outResult, 32'd101);
            @(negedge clk);
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp_inReadyRestore", inReady, 1);
        for (int i = 0; i < 5; i++) begin
            seen[i] = (outValid && outReady) ? {4'h0, outTag} : 8'hFF;
            @(posedge clk);
            #1 inValid = 1'b0;
            @(negedge clk);
            #1;
        end
        checkOutput("bp_drain0", seen[0], 8'd1);
        checkOutput("bp_drain1", seen[1], 8'd2);
        checkOutput("bp_drain2", seen[2], 8'd3);
        checkOutput("bp_drain3", seen[3], 8'hFF);
        checkOutput("bp_busyIdle", busy, 0);

        // Reset between clock edges with two operations in flight
        @(negedge clk);
        outReady = 1'b0;
        inValid = 1'b1; inOp = OP_ADD; inA = 32'd5; inB = 32'd5; inTag = 4'd5;
        @(posedge clk);
        #1 inTag = 4'd6;
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        checkOutput("mid_busyBefore", busy, 1);
        checkOutput("mid_validBefore", outValid, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_outValid", outValid, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_inReady", inReady, 1);
        checkOutput("mid_result", outResult, 0);
        checkOutput("mid_tag", outTag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        outReady = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (outValid) stale++;
        end
        checkOutput("mid_noStale", stale, 0);
        checkOutput("mid_inReadyAfter", inReady, 1);

        // Random streaming with random backpressure against the reference model
        accepted = 0;
        cycles = 0;
        while ((accepted < 1000 || sbq.size() > 0) && cycles < 20000) begin
            @(negedge clk);
            if (accepted < 1000) begin
                inValid = ($urandom_range(0, 3) != 0);
                inOp    = 3'($urandom_range(0, 7));
                inA     = pickOperand();
                inB     = pickOperand();
                inTag   = 4'($urandom_range(0, 15));
            end else begin
                inValid = 1'b0;
            end
            outReady = ($urandom_range(0, 2) != 0);
            #1;
            if (outValid && outReady) begin
                if (sbq.size() == 0) begin
                    checkOutput("stream_spurious", 1, 0);
                end else begin
                    expected = sbq.pop_front();
                    checkOutput("stream", {outTag, outFlags, outResult}, expected);
                end
            end
            if (inValid && inReady) begin
                sbq.push_back(refModel(inOp, inA, inB, inTag));
                accepted++;
            end
            cycles++;
        end
        checkOutput("stream_accepted", accepted, 1000);
        checkOutput("stream_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
